// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encodings and small operation-decoding helpers.
package mul_div_unit_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Signed operations take absolute values on entry and fix signs on exit.
    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // Divide operations share the upper opcode bit.
    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) ();

    logic             Start;
    md_op_e           Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Flush;
    logic             Stall;
    logic             Done;
    logic             DivByZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    // Pipeline side: issues requests, consumes results.
    modport master (
        output Start, Op, A, B, Flush,
        input  Stall, Done, DivByZero, Hi, Lo
    );

    // Unit side.
    modport slave (
        input  Start, Op, A, B, Flush,
        output Stall, Done, DivByZero, Hi, Lo
    );

endinterface

// File: rtl/mul_div_unit_cond_negate.sv
// Conditional two's complement: out = neg ? -in : in.
module md_cond_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_i,
    input  logic         neg_i,
    output logic [W-1:0] out_o
);

    // Negate when requested, otherwise pass the value through.
    always_comb begin
        if (neg_i) begin
            out_o = ~in_i + {{(W-1){1'b0}}, 1'b1};
        end else begin
            out_o = in_i;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit (MULT/MULTU/DIV/DIVU) feeding HI/LO.
// Operands are reduced to magnitudes on entry, WIDTH shift-add or
// shift-subtract steps run, then signs are fixed and HI/LO registered.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input logic            Clk,
    input logic            Rst,
    mul_div_unit_if.slave  md
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_op_e             op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    // Multiply: |A| (addend). Divide: |B| (divisor).
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // Multiply: product high/low halves. Divide: remainder / dividend-quotient.
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               start_ok_s;
    logic               start_signed_s;
    logic               a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   abs_a_s, abs_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    assign start_ok_s     = md.Start && !md.Flush;
    assign start_signed_s = md_is_signed(md.Op);
    assign a_neg_s        = start_signed_s && md.A[WIDTH-1];
    assign b_neg_s        = start_signed_s && md.B[WIDTH-1];

    md_cond_negate #(.W(WIDTH)) u_abs_a (
        .in_i (md.A), .neg_i (a_neg_s), .out_o (abs_a_s)
    );

    md_cond_negate #(.W(WIDTH)) u_abs_b (
        .in_i (md.B), .neg_i (b_neg_s), .out_o (abs_b_s)
    );

    md_cond_negate #(.W(2*WIDTH)) u_fix_prod (
        .in_i ({acc_hi_q, acc_lo_q}), .neg_i (sa_q ^ sb_q), .out_o (prod_fix_s)
    );

    md_cond_negate #(.W(WIDTH)) u_fix_quo (
        .in_i (acc_lo_q), .neg_i (sa_q ^ sb_q), .out_o (quo_fix_s)
    );

    // Remainder follows the sign of the dividend.
    md_cond_negate #(.W(WIDTH)) u_fix_rem (
        .in_i (acc_hi_q), .neg_i (sa_q), .out_o (rem_fix_s)
    );

    // One multiply step adds the multiplicand when the current multiplier LSB is set.
    assign mul_sum_s   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    // One restoring-divide step: shift in next dividend bit, trial-subtract the divisor.
    assign div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opnd_q};

    // FSM state and iteration counter register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> RUN (WIDTH steps) -> FIX -> IDLE, Flush aborts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (start_ok_s) begin
                    state_d = MD_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_RUN: begin
                if (md.Flush) begin
                    state_d = MD_IDLE;
                end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = MD_FIX;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    // Datapath next-state: operand capture, iteration steps and result fix-up.
    always_comb begin
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bzero_d  = bzero_q;
        a_raw_d  = a_raw_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start_ok_s) begin
                    op_d     = md.Op;
                    sa_d     = a_neg_s;
                    sb_d     = b_neg_s;
                    bzero_d  = (md.B == {WIDTH{1'b0}});
                    a_raw_d  = md.A;
                    acc_hi_d = {WIDTH{1'b0}};
                    if (md_is_div(md.Op)) begin
                        opnd_d   = abs_b_s;
                        acc_lo_d = abs_a_s;
                    end else begin
                        opnd_d   = abs_a_s;
                        acc_lo_d = abs_b_s;
                    end
                end else begin
                    done_d = 1'b0;
                end
            end
            MD_RUN: begin
                if (md.Flush) begin
                    done_d = 1'b0;
                end else if (md_is_div(op_q)) begin
                    if (!div_diff_s[WIDTH]) begin
                        acc_hi_d = div_diff_s[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift_s[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mul_sum_s[WIDTH:1];
                    acc_lo_d = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
                end
            end
            MD_FIX: begin
                if (md.Flush) begin
                    done_d = 1'b0;
                end else begin
                    done_d = 1'b1;
                    if (md_is_div(op_q)) begin
                        if (bzero_q) begin
                            dbz_d = 1'b1;
                            hi_d  = a_raw_q;
                            lo_d  = {WIDTH{1'b1}};
                        end else begin
                            hi_d = rem_fix_s;
                            lo_d = quo_fix_s;
                        end
                    end else begin
                        hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix_s[WIDTH-1:0];
                    end
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and result registers; reset clears everything, discarding partial work.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            op_q     <= MD_MULT;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bzero_q  <= 1'b0;
            a_raw_q  <= {WIDTH{1'b0}};
            opnd_q   <= {WIDTH{1'b0}};
            acc_hi_q <= {WIDTH{1'b0}};
            acc_lo_q <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bzero_q  <= bzero_d;
            a_raw_q  <= a_raw_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    // Stall is decoded straight from state so hazard logic freezes the pipe on the start edge.
    assign md.Stall     = (state_q != MD_IDLE);
    assign md.Done      = done_q;
    assign md.DivByZero = dbz_q;
    assign md.Hi        = hi_q;
    assign md.Lo        = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic Clk;
    logic Rst;
    int   checks;
    int   failures;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .md  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference result {DivByZero, Hi, Lo} from plain integer arithmetic.
    function automatic logic [64:0] ref_md(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_MULT: begin
                sp = sa * sb;
                return {1'b0, sp[63:0]};
            end
            MD_MULTU: begin
                up = ua * ub;
                return {1'b0, up[63:0]};
            end
            MD_DIV: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {1'b0, sr[31:0], sq[31:0]};
            end
            MD_DIVU: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {1'b0, ur[31:0], uq[31:0]};
            end
            default: return 65'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a one-cycle Start; returns at the negedge after the accepting edge.
    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge Clk);
        bus.Start = 1'b0;
    endtask

    // Wait (bounded) for Done; n = cycles since the accepting edge, st = stalled cycles.
    task automatic wait_done(input int n0, output int n, output int st);
        n  = n0;
        st = 0;
        while (bus.Done !== 1'b1 && n < 100) begin
            if (bus.Stall === 1'b1) st++;
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic check_op(input string tag, input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        int          n, st;
        logic [64:0] e;
        e = ref_md(op, a, b);
        issue(op, a, b);
        wait_done(0, n, st);
        chk({tag, ".latency"}, 64'(n), 64'd33);
        chk({tag, ".stall"}, 64'(st), 64'd33);
        chk({tag, ".hi"}, {32'd0, bus.Hi}, {32'd0, e[63:32]});
        chk({tag, ".lo"}, {32'd0, bus.Lo}, {32'd0, e[31:0]});
        chk({tag, ".dbz"}, {63'd0, bus.DivByZero}, {63'd0, e[64]});
        @(negedge Clk);
        chk({tag, ".done_pulse"}, {62'd0, bus.Done, bus.DivByZero}, 64'd0);
        chk({tag, ".hold"}, {bus.Hi, bus.Lo}, e[63:0]);
    endtask

    initial begin
        int          n, st;
        logic        seen;
        md_op_e      rop;
        logic [31:0] ra, rb;
        checks    = 0;
        failures  = 0;
        Rst       = 1'b1;
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        bus.Op    = MD_MULT;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        repeat (2) @(negedge Clk);
        chk("reset.outputs", {59'd0, bus.Stall, bus.Done, bus.DivByZero, 2'b00}, 64'd0);
        chk("reset.hilo", {bus.Hi, bus.Lo}, 64'd0);
        Rst = 1'b0;

        // Directed cases.
        check_op("multu_7x6", MD_MULTU, 32'd7, 32'd6);
        check_op("mult_m3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5);
        check_op("multu_m3x5", MD_MULTU, 32'hFFFF_FFFD, 32'd5);
        chk("multu_m3x5.const", {bus.Hi, bus.Lo}, 64'h0000_0004_FFFF_FFF1);
        check_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2.const", {bus.Hi, bus.Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        check_op("divu_100_7", MD_DIVU, 32'd100, 32'd7);
        check_op("divu_by0", MD_DIVU, 32'h64, 32'd0);
        check_op("div_by0", MD_DIV, 32'hFFFF_FFF0, 32'd0);
        check_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf.const", {bus.Hi, bus.Lo}, 64'h0000_0000_8000_0000);
        check_op("mult_minxmin", MD_MULT, 32'h8000_0000, 32'h8000_0000);

        // Start while busy is ignored.
        issue(MD_MULTU, 32'd7, 32'd6);
        repeat (9) @(negedge Clk);
        bus.Start = 1'b1;
        bus.Op    = MD_DIVU;
        bus.A     = 32'd123;
        bus.B     = 32'd456;
        @(negedge Clk);
        bus.Start = 1'b0;
        wait_done(10, n, st);
        chk("busy_start.latency", 64'(n), 64'd33);
        chk("busy_start.result", {bus.Hi, bus.Lo}, 64'd42);
        @(negedge Clk);
        chk("busy_start.no_second", {63'd0, bus.Stall}, 64'd0);

        // Flush mid-RUN aborts with no result.
        issue(MD_MULT, 32'hFFFF_FFFF, 32'h0001_2345);
        repeat (19) @(negedge Clk);
        bus.Flush = 1'b1;
        @(negedge Clk);
        bus.Flush = 1'b0;
        chk("flush.idle", {63'd0, bus.Stall}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen = seen | bus.Done;
            @(negedge Clk);
        end
        chk("flush.no_done", {63'd0, seen}, 64'd0);
        chk("flush.hilo_kept", {bus.Hi, bus.Lo}, 64'd42);

        // Flush in IDLE blocks Start.
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Flush = 1'b1;
        bus.Op    = MD_MULTU;
        @(negedge Clk);
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        chk("idle_flush.no_start", {63'd0, bus.Stall}, 64'd0);

        // Random operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            rop = md_op_e'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
                3: ra = {16'hFFFF, ra[15:0]};
                default: ;
            endcase
            check_op($sformatf("rand%0d", i), rop, ra, rb);
        end

        // Async reset mid-RUN clears outputs before the next edge.
        issue(MD_MULTU, 32'd5, 32'd5);
        repeat (14) @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        chk("rst_mid.outputs", {61'd0, bus.Stall, bus.Done, bus.DivByZero}, 64'd0);
        chk("rst_mid.hilo", {bus.Hi, bus.Lo}, 64'd0);
        @(negedge Clk);
        Rst = 1'b0;
        check_op("after_rst_3x3", MD_MULTU, 32'd3, 32'd3);
        chk("after_rst_3x3.const", {bus.Hi, bus.Lo}, 64'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
